// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling UART receiver (8 data bits, LSB first, 1 stop bit).
// Samples the synchronized rx line OVERSAMPLE times per bit, validates the start
// bit at its centre and samples each following bit at its centre.
// Optional feature macro: UART_RX_PARITY_EN adds an even-parity bit and parity_err.
module uart_rx_os #(
    parameter int CLK_FREQ   = 1000000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] doutrx,
    output logic       donerx,
    output logic       frame_err,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       busy
);

    localparam int DIV_RAW = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SCW     = $clog2(OVERSAMPLE);
    localparam logic [DW-1:0]  DIV_LAST = DW'(DIV - 1);
    localparam logic [SCW-1:0] SC_HALF  = SCW'(OVERSAMPLE / 2 - 1);
    localparam logic [SCW-1:0] SC_LAST  = SCW'(OVERSAMPLE - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
`endif

    state_t         state, state_n;
    logic           rx_meta, rs;
    logic [DW-1:0]  div_cnt;
    logic           tick;
    logic           div_restart;
    logic [SCW-1:0] sc, sc_n;
    logic [2:0]     bit_cnt, bit_cnt_n;
    logic [7:0]     shreg, shreg_n;
    logic [7:0]     dout_n;
    logic           done_n, ferr_n;
`ifdef UART_RX_PARITY_EN
    logic           par_bit, par_bit_n;
    logic           perr_n;
`endif

    assign tick = (div_cnt == DIV_LAST);
    assign busy = (state != IDLE) && (state != START);

    // Two-flop synchronizer; both stages idle high so reset looks like an idle line
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rs      <= 1'b1;
        end else begin
            rx_meta <= rx;
            rs      <= rx_meta;
        end
    end

    // Oversample tick divider, realigned to the start edge so ticks are phase-locked to the frame
    always_ff @(posedge clk) begin
        if (!rst) begin
            div_cnt <= '0;
        end else if (div_restart || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    // State, counters, shift register and output strobes
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            sc        <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            doutrx    <= 8'h00;
            donerx    <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            sc        <= sc_n;
            bit_cnt   <= bit_cnt_n;
            shreg     <= shreg_n;
            doutrx    <= dout_n;
            donerx    <= done_n;
            frame_err <= ferr_n;
`ifdef UART_RX_PARITY_EN
            par_bit    <= par_bit_n;
            parity_err <= perr_n;
`endif
        end
    end

    // Next-state logic: every sampling decision is taken at a bit centre on a tick
    always_comb begin
        state_n     = state;
        sc_n        = sc;
        bit_cnt_n   = bit_cnt;
        shreg_n     = shreg;
        dout_n      = doutrx;
        done_n      = 1'b0;
        ferr_n      = 1'b0;
        div_restart = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_n   = par_bit;
        perr_n      = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (!rs) begin
                    state_n     = START;
                    sc_n        = '0;
                    div_restart = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    if (sc == SC_HALF) begin
                        sc_n = '0;
                        if (!rs) begin
                            state_n   = DATA;
                            bit_cnt_n = '0;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        sc_n = sc + SCW'(1);
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (sc == SC_LAST) begin
                        sc_n      = '0;
                        shreg_n   = {rs, shreg[7:1]};
                        bit_cnt_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_n = PARITY;
`else
                            state_n = STOP;
`endif
                        end
                    end else begin
                        sc_n = sc + SCW'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    if (sc == SC_LAST) begin
                        sc_n      = '0;
                        par_bit_n = rs;
                        state_n   = STOP;
                    end else begin
                        sc_n = sc + SCW'(1);
                    end
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    if (sc == SC_LAST) begin
                        sc_n = '0;
                        if (rs) begin
                            dout_n  = shreg;
                            done_n  = 1'b1;
                            state_n = IDLE;
`ifdef UART_RX_PARITY_EN
                            perr_n  = ^{shreg, par_bit};
`endif
                        end else begin
                            ferr_n  = 1'b1;
                            state_n = WAIT_IDLE;
                        end
                    end else begin
                        sc_n = sc + SCW'(1);
                    end
                end
            end
            WAIT_IDLE: begin
                if (rs) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: randomized self-checking bench for uart_rx_os.
// A frame-level model records what each transmitted frame should produce
// (received byte, parity flag or framing error); a monitor collects what the DUT reports.
// Optional feature macro: UART_RX_PARITY_EN.
module tb_uart_rx_os;

    localparam int CLK_FREQ   = 1000000;
    localparam int BAUD       = 9600;
    localparam int OVERSAMPLE = 16;
    localparam int BIT_CLK    = (CLK_FREQ / (BAUD * OVERSAMPLE)) * OVERSAMPLE;
`ifdef UART_RX_PARITY_EN
    localparam int EXP_LAT    = (21 * BIT_CLK) / 2 + 2;
`else
    localparam int EXP_LAT    = (19 * BIT_CLK) / 2 + 2;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] doutrx;
    logic       donerx;
    logic       frame_err;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0] exp_q[$];
    logic       exp_perr_q[$];
    logic [7:0] done_q[$];
    logic       done_perr_q[$];
    int         exp_ferr     = 0;
    int         seen_ferr    = 0;
    int         both_count   = 0;
    int         long_pulses  = 0;
    int         orphan_perr  = 0;
    bit         busy_seen    = 1'b0;
    logic       prev_done    = 1'b0;
    int         start_cyc    = 0;
    int         done_cyc     = 0;
    logic [7:0] last_good    = 8'h00;

    uart_rx_os #(
        .CLK_FREQ(CLK_FREQ),
        .BAUD(BAUD),
        .OVERSAMPLE(OVERSAMPLE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx(rx),
        .doutrx(doutrx),
        .donerx(donerx),
        .frame_err(frame_err),
`ifdef UART_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .busy(busy)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Cycle counter used for latency measurement
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: collect DUT reports half a cycle after each active edge
    always @(negedge clk) begin
        logic perr_now;
`ifdef UART_RX_PARITY_EN
        perr_now = parity_err;
`else
        perr_now = 1'b0;
`endif
        if (donerx) begin
            done_q.push_back(doutrx);
            done_perr_q.push_back(perr_now);
            done_cyc = cyc;
        end
        if (frame_err) seen_ferr++;
        if (donerx && frame_err) both_count++;
        if (donerx && prev_done) long_pulses++;
        if (perr_now && !donerx) orphan_perr++;
        if (busy) busy_seen = 1'b1;
        prev_done = donerx;
    end

    // Single comparison point; every check in the bench goes through here
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic waitClocks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Transmit one frame and record what the reference model says it should produce
    task automatic applyStimulus(input logic [7:0] data, input logic stop_bit, input logic par_bit);
        if (stop_bit) begin
            exp_q.push_back(data);
            exp_perr_q.push_back(^{data, par_bit});
            last_good = data;
        end else begin
            exp_ferr++;
        end
        start_cyc = cyc;
        rx = 1'b0;
        waitClocks(BIT_CLK);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            waitClocks(BIT_CLK);
        end
`ifdef UART_RX_PARITY_EN
        rx = par_bit;
        waitClocks(BIT_CLK);
`endif
        rx = stop_bit;
        waitClocks(BIT_CLK);
        rx = 1'b1;
    endtask

    // Compare reported frames against the model, in order, then clear both sides
    task automatic checkFrames(input string tag);
        checkOutput({tag, "_count"}, done_q.size(), exp_q.size());
        while (done_q.size() > 0 && exp_q.size() > 0) begin
            checkOutput({tag, "_byte"}, done_q.pop_front(), exp_q.pop_front());
            checkOutput({tag, "_perr"}, done_perr_q.pop_front(), exp_perr_q.pop_front());
        end
        done_q.delete();
        done_perr_q.delete();
        exp_q.delete();
        exp_perr_q.delete();
    endtask

    initial begin
        logic [7:0] b;
        int lat;

        // Reset with idle line
        rst = 1'b0;
        rx  = 1'b1;
        waitClocks(5);
        checkOutput("rst_doutrx", doutrx, 8'h00);
        checkOutput("rst_donerx", donerx, 1'b0);
        checkOutput("rst_frame_err", frame_err, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        rst = 1'b1;
        waitClocks(20);

        // Single good frame, including latency from start edge
        applyStimulus(8'hA5, 1'b1, ^8'hA5);
        waitClocks(10);
        lat = done_cyc - start_cyc;
        checkOutput("a5_latency_in_range", (lat >= EXP_LAT - 4) && (lat <= EXP_LAT + 4), 1);
        checkOutput("a5_doutrx", doutrx, 8'hA5);
        checkFrames("a5");
        checkOutput("a5_no_ferr", seen_ferr, exp_ferr);

        // Glitch shorter than half a bit must be rejected
        busy_seen = 1'b0;
        rx = 1'b0;
        waitClocks(20);
        rx = 1'b1;
        waitClocks(BIT_CLK);
        checkOutput("glitch_busy", busy_seen, 1'b0);
        checkFrames("glitch");
        applyStimulus(8'h3C, 1'b1, ^8'h3C);
        waitClocks(10);
        checkFrames("after_glitch");

        // Framing error with line held low (break), then recovery
        applyStimulus(8'h5A, 1'b0, ^8'h5A);
        rx = 1'b0;
        waitClocks(300);
        rx = 1'b1;
        waitClocks(20);
        checkOutput("ferr_count", seen_ferr, exp_ferr);
        checkOutput("ferr_doutrx_held", doutrx, last_good);
        checkFrames("ferr_no_done");
        applyStimulus(8'h0F, 1'b1, ^8'h0F);
        waitClocks(10);
        checkFrames("after_ferr");

        // Back-to-back random frames with no idle gap
        for (int i = 0; i < 10; i++) begin
            b = 8'($urandom_range(0, 255));
            applyStimulus(b, 1'b1, ^b);
        end
        waitClocks(10);
        checkFrames("b2b");

        // Reset pulse during bit 4 of 8'hFF aborts the frame
        rx = 1'b0;
        waitClocks(BIT_CLK);
        rx = 1'b1;
        waitClocks(4 * BIT_CLK + BIT_CLK / 2);
        checkOutput("midrst_busy_before", busy, 1'b1);
        rst = 1'b0;
        waitClocks(1);
        last_good = 8'h00;
        checkOutput("midrst_doutrx", doutrx, 8'h00);
        checkOutput("midrst_busy", busy, 1'b0);
        checkOutput("midrst_donerx", donerx, 1'b0);
        rst = 1'b1;
        waitClocks(6 * BIT_CLK);
        checkFrames("midrst_no_strobe");
        checkOutput("midrst_doutrx_after", doutrx, last_good);
        applyStimulus(8'h81, 1'b1, ^8'h81);
        waitClocks(10);
        checkFrames("after_midrst");

`ifdef UART_RX_PARITY_EN
        // Parity: correct even parity, then a flipped parity bit
        applyStimulus(8'h07, 1'b1, 1'b1);
        waitClocks(10);
        checkFrames("par_ok");
        applyStimulus(8'h07, 1'b1, 1'b0);
        waitClocks(10);
        checkOutput("par_bad_doutrx", doutrx, 8'h07);
        checkFrames("par_bad");
`endif

        // Whole-run invariants
        checkOutput("total_ferr", seen_ferr, exp_ferr);
        checkOutput("done_ferr_exclusive", both_count, 0);
        checkOutput("done_single_cycle", long_pulses, 0);
        checkOutput("perr_only_with_done", orphan_perr, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
